debounce_event_core: RTL
========================

// Module: debounce_event_core
// PURPOSE
//  Sits directly downstream of the per-button debounce FSMs and consumes their db outputs.
//  Per channel it provides:
//   - rise/fall edge detection with sticky W1C event flags
//   - a long-press (hold) detector timed by the shared ms10_tick
//   - a saturating press counter
//  Results are exposed as an MMIO slot (cs/read/write/addr) with a level interrupt.
// PARAMETERS
//  W           8    number of debounced channels (1..8)
//  HOLD_TICKS  100  ms10_tick count for a hold event (1..255; 0 disables hold detection)
// PORTS
//  clk       in   1   system clock
//  reset_n   in   1   asynchronous, active-low reset
//  ms10_tick in   1   one-cycle 10 ms strobe, shared with the debounce FSMs
//  db_in     in   W   debounced levels, synchronous to clk
//  cs        in   1   slot select
//  read      in   1   read strobe (qualified by cs)
//  write     in   1   write strobe (qualified by cs)
//  addr      in   5   word address within the slot
//  wr_data   in   32  write data
//  rd_data   out  32  read data, combinational from addr
//  irq       out  1   registered level interrupt
// BEHAVIOUR
//  Reset (async, reset_n=0): all of these clear to 0 and irq=0:
//   db_prev, rise_ev, fall_ev, hold_ev, irq_en, hold timers, hold_done, counters.
//  Edge detect, each clk:
//   - db_prev <= db_in
//   - rise = db_in & ~db_prev; fall = ~db_in & db_prev
//   - Event flags are set on the same clk edge; readable on the next cycle (1-cycle latency).
//   - db_in high at reset release is a rise event.
//  Register map (word addr):
//   0  RO  db_in levels, bits [W-1:0]
//   1  W1C rise_ev
//   2  W1C fall_ev
//   3  W1C hold_ev
//   4  RW  irq_en[3*W-1:0] as {hold, fall, rise}
//   8+i RO/WC press counter of channel i, 16 bits, zero-extended
//   Unmapped addresses read 0; writes to them are ignored.
//   Bits above the field width read 0.
//  Write behaviour:
//   - W1C: set bits in wr_data clear the matching flags.
//   - Set and clear on the same cycle: set wins, flag stays 1.
//   - Any write to 8+i clears counter i.
//   - Write to 8+i with a rise on channel i in the same cycle: counter = 1.
//  Counter: increments on rise; saturates at 0xFFFF.
//  Hold FSM, per channel: IDLE -> TIMING -> HELD.
//   - IDLE: timer=0; rise -> TIMING.
//   - TIMING: +1 per ms10_tick while db_in=1.
//     When the timer reaches HOLD_TICKS: set hold_ev, go to HELD.
//   - HELD: no further hold events until release.
//   - Any state with db_in=0 -> IDLE, timer=0.
//   - HOLD_TICKS=0: the FSM stays in IDLE and never sets hold_ev.
//  irq <= |({hold_ev,fall_ev,rise_ev} & irq_en).
//   Visible one cycle after the flag; deasserts one cycle after the flag or enable clears.
//  read has no side effects; rd_data is valid in the cycle addr is applied.
//  Reset mid-hold or mid-count discards all state immediately; no event is generated.
// TESTING
//  - Reset: reset_n=0 with db_in=0 -> rd_data=0 at all addresses; irq=0.
//  - db_in[2] 0->1 at cycle N -> addr1 reads 0x04 from N+1; counter @addr10 = 1.
//    Write addr1 = 0x04 -> reads 0.
//  - irq_en=0x001 and db_in[0] rise -> irq=1 two cycles later.
//    Write addr1=0x01 in the same cycle as a new rise -> flag and irq stay 1.
//  - HOLD_TICKS=3, db_in[1] held high:
//    - 3 ms10_ticks -> hold_ev = 0x02 after the 3rd tick.
//    - 10 more ticks -> no second event.
//    - Release, re-press, release after 2 ticks -> no new event.
//  - 65537 rises on channel 0 -> counter reads 0xFFFF.
//    Write addr8 together with a rise -> counter reads 1.
//  - Assert reset_n=0 mid-hold (timer=2) -> all state 0.
//    After release, 3 ticks of high input are needed for a hold event.

Source files
------------

// File: rtl/debounce_event_core.sv
// rtl/debounce_event_core.sv - per-channel edge, hold and press-count events behind an MMIO slot with a level irq
module debounce_event_core #(
  parameter int W          = 8,    // debounced channels, 1..8
  parameter int HOLD_TICKS = 100,  // ms10_tick count for a hold event, 0 disables hold detection
  parameter int CNT_W      = 16    // press counter width, read back zero-extended
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         ms10_tick,
  input  logic [W-1:0] db_in,
  input  logic         cs,
  input  logic         read,
  input  logic         write,
  input  logic [4:0]   addr,
  input  logic [31:0]  wr_data,
  output logic [31:0]  rd_data,
  output logic         irq
);

  // Hold FSM encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_TIMING = 2'd1;
  localparam logic [1:0] ST_HELD   = 2'd2;

  localparam logic [7:0] HOLD_T = 8'(HOLD_TICKS);

  // Word addresses inside the slot
  localparam logic [4:0] A_LEVEL = 5'd0;
  localparam logic [4:0] A_RISE  = 5'd1;
  localparam logic [4:0] A_FALL  = 5'd2;
  localparam logic [4:0] A_HOLD  = 5'd3;
  localparam logic [4:0] A_IRQEN = 5'd4;
  localparam int         A_CNT0  = 8;

  logic [W-1:0]     db_prev_q, db_prev_d;
  logic [W-1:0]     rise_ev_q, rise_ev_d;
  logic [W-1:0]     fall_ev_q, fall_ev_d;
  logic [W-1:0]     hold_ev_q, hold_ev_d;
  logic [3*W-1:0]   irq_en_q, irq_en_d;
  logic             irq_q, irq_d;
  logic [1:0]       hstate_q [W];
  logic [1:0]       hstate_d [W];
  logic [7:0]       timer_q  [W];
  logic [7:0]       timer_d  [W];
  logic [CNT_W-1:0] cnt_q    [W];
  logic [CNT_W-1:0] cnt_d    [W];

  logic [W-1:0] rise;
  logic [W-1:0] fall;
  logic [W-1:0] hold_set;
  logic         wr_en;
  logic [W-1:0] clr_rise;
  logic [W-1:0] clr_fall;
  logic [W-1:0] clr_hold;
  logic [W-1:0] cnt_clr;

  // Reads carry no side effects and the upper write bits have no field behind them.
  logic unused_inputs;
  assign unused_inputs = ^{read, wr_data[31:3*W]};

  assign wr_en = cs & write;
  assign rise  = db_in & ~db_prev_q;
  assign fall  = ~db_in & db_prev_q;

  // Write decode: W1C masks for the flag words and per-channel counter clears
  always_comb begin
    clr_rise = '0;
    clr_fall = '0;
    clr_hold = '0;
    cnt_clr  = '0;
    if (wr_en) begin
      if (addr == A_RISE) clr_rise = wr_data[W-1:0];
      if (addr == A_FALL) clr_fall = wr_data[W-1:0];
      if (addr == A_HOLD) clr_hold = wr_data[W-1:0];
      for (int i = 0; i < W; i++) begin
        if (addr == 5'(A_CNT0 + i)) cnt_clr[i] = 1'b1;
      end
    end
  end

  // Hold FSM per channel: a release always returns to idle; the timer only runs while timing
  always_comb begin
    hold_set = '0;
    for (int i = 0; i < W; i++) begin
      hstate_d[i] = hstate_q[i];
      timer_d[i]  = timer_q[i];
      if (HOLD_TICKS == 0 || !db_in[i]) begin
        hstate_d[i] = ST_IDLE;
        timer_d[i]  = '0;
      end else begin
        case (hstate_q[i])
          ST_IDLE: begin
            timer_d[i] = '0;
            if (rise[i]) hstate_d[i] = ST_TIMING;
          end
          ST_TIMING: begin
            if (ms10_tick) begin
              if (timer_q[i] + 8'd1 == HOLD_T) begin
                hold_set[i] = 1'b1;
                hstate_d[i] = ST_HELD;
                timer_d[i]  = HOLD_T;
              end else begin
                timer_d[i] = timer_q[i] + 8'd1;
              end
            end
          end
          ST_HELD: begin
            hstate_d[i] = ST_HELD;
          end
          default: begin
            hstate_d[i] = ST_IDLE;
            timer_d[i]  = '0;
          end
        endcase
      end
    end
  end

  // Sticky flags: a new event in the same cycle as its W1C clear keeps the flag set
  always_comb begin
    db_prev_d = db_in;
    rise_ev_d = (rise_ev_q & ~clr_rise) | rise;
    fall_ev_d = (fall_ev_q & ~clr_fall) | fall;
    hold_ev_d = (hold_ev_q & ~clr_hold) | hold_set;
    irq_en_d  = irq_en_q;
    if (wr_en && addr == A_IRQEN) irq_en_d = wr_data[3*W-1:0];
    irq_d = |({hold_ev_q, fall_ev_q, rise_ev_q} & irq_en_q);
  end

  // Saturating press counters; a clear coinciding with a press leaves a count of one
  always_comb begin
    for (int i = 0; i < W; i++) begin
      cnt_d[i] = cnt_q[i];
      if (cnt_clr[i]) begin
        cnt_d[i] = rise[i] ? CNT_W'(1) : '0;
      end else if (rise[i] && cnt_q[i] != {CNT_W{1'b1}}) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Combinational read mux; unmapped words and unused upper bits read zero
  always_comb begin
    rd_data = '0;
    case (addr)
      A_LEVEL: rd_data[W-1:0]   = db_in;
      A_RISE:  rd_data[W-1:0]   = rise_ev_q;
      A_FALL:  rd_data[W-1:0]   = fall_ev_q;
      A_HOLD:  rd_data[W-1:0]   = hold_ev_q;
      A_IRQEN: rd_data[3*W-1:0] = irq_en_q;
      default: begin
        for (int i = 0; i < W; i++) begin
          if (addr == 5'(A_CNT0 + i)) rd_data[CNT_W-1:0] = cnt_q[i];
        end
      end
    endcase
  end

  // State registers; reset discards any partial hold or count without raising events
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db_prev_q <= '0;
      rise_ev_q <= '0;
      fall_ev_q <= '0;
      hold_ev_q <= '0;
      irq_en_q  <= '0;
      irq_q     <= 1'b0;
      for (int i = 0; i < W; i++) begin
        hstate_q[i] <= ST_IDLE;
        timer_q[i]  <= '0;
        cnt_q[i]    <= '0;
      end
    end else begin
      db_prev_q <= db_prev_d;
      rise_ev_q <= rise_ev_d;
      fall_ev_q <= fall_ev_d;
      hold_ev_q <= hold_ev_d;
      irq_en_q  <= irq_en_d;
      irq_q     <= irq_d;
      for (int i = 0; i < W; i++) begin
        hstate_q[i] <= hstate_d[i];
        timer_q[i]  <= timer_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
    end
  end

  assign irq = irq_q;

endmodule
